// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared types and constants for the HI/LO divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

  // Default operand/result width
  localparam int DIV_W = 32;

  // Iteration counter width (holds DIV_W at the default width)
  localparam int CNT_W = 6;

  // Quotient written to LO on divide by zero
  localparam logic [DIV_W-1:0] DZ_QUOT = '1;

  // Divide sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage : div_pkg
`default_nettype wire

// File: rtl/divu_core.sv
`default_nettype none
// ============================================================================
// Module   : divu_core
// Brief    : Iterative unsigned restoring divider, one quotient bit per cycle.
//            Dividend bits are shifted out of q as quotient bits shift in.
// Revision : 1.0 - initial release
// ============================================================================
module divu_core
  import div_pkg::*;
#(
  parameter int DIV_W = div_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] q,
  output logic [DIV_W-1:0] r,
  output logic             finish
);

  logic [DIV_W-1:0] r_q;
  logic [DIV_W-1:0] r_r;
  logic [DIV_W-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;

  logic [DIV_W:0]   w_trial;
  logic             w_fits;

  // Trial subtraction of the divisor from the shifted partial remainder;
  // the top bit of the (DIV_W+1)-bit difference is the borrow.
  assign w_trial = {r_r, r_q[DIV_W-1]} - {1'b0, r_d};
  assign w_fits  = ~w_trial[DIV_W];

  // Load operands, then resolve one quotient bit per cycle until the counter empties
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q   <= '0;
      r_r   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_q   <= dividend;
      r_r   <= '0;
      r_d   <= divisor;
      r_cnt <= CNT_W'(DIV_W);
    end else if (r_cnt != '0) begin
      if (w_fits) begin
        r_r <= w_trial[DIV_W-1:0];
        r_q <= {r_q[DIV_W-2:0], 1'b1};
      end else begin
        r_r <= {r_r[DIV_W-2:0], r_q[DIV_W-1]};
        r_q <= {r_q[DIV_W-2:0], 1'b0};
      end
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign q = r_q;
  assign r = r_r;
  // High during the last iteration: the counter reaches 0 on this edge
  assign finish = (r_cnt == CNT_W'(1));

endmodule : divu_core
`default_nettype wire

// File: rtl/hilo_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_div_unit
// Brief    : MIPS-style HI/LO register pair with an iterative DIV/DIVU engine
//            and MTHI/MTLO write port. LO = quotient, HI = remainder.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_div_unit
  import div_pkg::*;
#(
  parameter int DIV_W = div_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [DIV_W-1:0] op_a,
  input  logic [DIV_W-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [DIV_W-1:0] wdata,
  output logic [DIV_W-1:0] hi,
  output logic [DIV_W-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero
);

  // All-ones quotient replicated to the instance width
  localparam logic [DIV_W-1:0] c_DZ_QUOT = {DIV_W{DZ_QUOT[0]}};

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_accept;
  logic             w_core_load;

  logic             w_b_zero;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [DIV_W-1:0] w_abs_a;
  logic [DIV_W-1:0] w_abs_b;

  logic [DIV_W-1:0] w_core_q;
  logic [DIV_W-1:0] w_core_r;
  logic             w_core_finish;

  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_div_zero;
  logic [DIV_W-1:0] r_a_raw;
  logic [DIV_W-1:0] r_hi;
  logic [DIV_W-1:0] r_lo;
  logic             r_done;

  // Operand magnitudes; sign bits only matter for DIV
  assign w_b_zero = (op_b == '0);
  assign w_neg_a  = is_signed & op_a[DIV_W-1];
  assign w_neg_b  = is_signed & op_b[DIV_W-1];
  assign w_abs_a  = w_neg_a ? (-op_a) : op_a;
  assign w_abs_b  = w_neg_b ? (-op_b) : op_b;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control: starts are only taken in IDLE; divide by zero bypasses RUN
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_core_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (w_b_zero) begin
            w_state_nxt = FIX;
          end else begin
            w_state_nxt = RUN;
            w_core_load = 1'b1;
          end
        end
      end
      RUN: begin
        if (w_core_finish) begin
          w_state_nxt = FIX;
        end
      end
      FIX: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Capture result signs, raw dividend and the zero-divisor flag when a divide is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_div_zero <= 1'b0;
      r_a_raw    <= '0;
    end else if (w_accept) begin
      r_sign_q   <= w_neg_a ^ w_neg_b;
      r_sign_r   <= w_neg_a;
      r_div_zero <= w_b_zero;
      r_a_raw    <= op_a;
    end
  end

  // HI/LO: divide results land in FIX; MTHI/MTLO only take effect in IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == FIX) begin
      if (r_div_zero) begin
        r_lo <= c_DZ_QUOT;
        r_hi <= r_a_raw;
      end else begin
        r_lo <= r_sign_q ? (-w_core_q) : w_core_q;
        r_hi <= r_sign_r ? (-w_core_r) : w_core_r;
      end
    end else if (r_state == IDLE) begin
      if (hi_we) begin
        r_hi <= wdata;
      end
      if (lo_we) begin
        r_lo <= wdata;
      end
    end
  end

  // One-cycle completion pulse following the FIX edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == FIX);
    end
  end

  divu_core #(
    .DIV_W (DIV_W)
  ) u_divu_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_core_load),
    .dividend (w_abs_a),
    .divisor  (w_abs_b),
    .q        (w_core_q),
    .r        (w_core_r),
    .finish   (w_core_finish)
  );

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = (r_state != IDLE);
  assign stall    = start | busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule : hilo_div_unit
`default_nettype wire

// File: tb/tb_hilo_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_div_unit
// Brief    : Self-checking bench for hilo_div_unit: directed cases plus
//            randomized divides and MTHI/MTLO writes against a plain
//            arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         stall;
  logic         done;
  logic         div_zero;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] m_hi  = '0;
  logic [W-1:0] m_lo  = '0;

  hilo_div_unit #(
    .DIV_W (W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics from plain integer arithmetic
  function automatic void ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    int sa;
    int sb;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = '0;
      end else begin
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic mt_write(input bit whi, input bit wlo, input logic [W-1:0] wd);
    @(negedge clk);
    hi_we = whi;
    lo_we = wlo;
    wdata = wd;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    if (whi) m_hi = wd;
    if (wlo) m_lo = wd;
    check_val("mt.hi", 64'(hi), 64'(m_hi));
    check_val("mt.lo", 64'(lo), 64'(m_lo));
  endtask

  task automatic run_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit mthi, input bit mtlo, input logic [W-1:0] wd,
                         input bit rel_rst);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    int           k;
    int           lat_exp;
    string        nm;
    nm = $sformatf("%s%0h/%0h", sgn ? "div " : "divu ", a, b);
    ref_div(sgn, a, b, eq, er);
    lat_exp = (b == 0) ? 1 : W + 1;
    @(negedge clk);
    if (rel_rst) reset_n = 1'b1;
    start     = 1'b1;
    is_signed = sgn;
    op_a      = a;
    op_b      = b;
    hi_we     = mthi;
    lo_we     = mtlo;
    wdata     = wd;
    #1;
    check_val({nm, " stall"}, 64'(stall), 64'(1));
    @(posedge clk);
    #1;
    start     = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    op_a      = $urandom;
    op_b      = $urandom;
    is_signed = 1'($urandom);
    if (mthi) m_hi = wd;
    if (mtlo) m_lo = wd;
    check_val({nm, " acc.hi"}, 64'(hi), 64'(m_hi));
    check_val({nm, " acc.lo"}, 64'(lo), 64'(m_lo));
    check_val({nm, " acc.busy"}, 64'(busy), 64'(1));
    if (b != 0) check_val({nm, " acc.dz"}, 64'(div_zero), 64'(0));
    for (k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    check_val({nm, " latency"}, 64'(k), 64'(lat_exp));
    check_val({nm, " lo"}, 64'(lo), 64'(eq));
    check_val({nm, " hi"}, 64'(hi), 64'(er));
    check_val({nm, " dz"}, 64'(div_zero), 64'(b == 0));
    check_val({nm, " busy"}, 64'(busy), 64'(0));
    m_hi = er;
    m_lo = eq;
    @(posedge clk);
    #1;
    check_val({nm, " done1"}, 64'(done), 64'(0));
  endtask

  initial begin
    int  k;
    bit  saw;
    bit  sg;
    logic [W-1:0] a;
    logic [W-1:0] b;

    reset_n   = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    op_a      = '0;
    op_b      = '0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    wdata     = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst.hi", 64'(hi), 64'(0));
    check_val("rst.lo", 64'(lo), 64'(0));
    check_val("rst.busy", 64'(busy), 64'(0));
    check_val("rst.done", 64'(done), 64'(0));
    check_val("rst.dz", 64'(div_zero), 64'(0));
    check_val("rst.stall", 64'(stall), 64'(0));
    reset_n = 1'b1;

    // Directed arithmetic cases
    run_div(1'b0, 32'd100, 32'd7, 1'b0, 1'b0, '0, 1'b0);
    run_div(1'b1, -32'sd7, 32'd2, 1'b0, 1'b0, '0, 1'b0);
    run_div(1'b1, 32'd7, -32'sd2, 1'b0, 1'b0, '0, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0);
    run_div(1'b0, 32'd5, 32'd0, 1'b0, 1'b0, '0, 1'b0);
    run_div(1'b0, 32'd9, 32'd3, 1'b0, 1'b0, '0, 1'b0);

    // Restart and MTHI while busy must be ignored
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; op_a = 32'd50; op_b = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (k = 1; k <= 100; k++) begin
      if (k == 10) begin
        start = 1'b1; op_a = 32'd1; op_b = 32'd1;
      end
      if (k == 12) begin
        hi_we = 1'b1; wdata = 32'hAAAA;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      hi_we = 1'b0;
      if (k == 12) check_val("busy.mthi_ignored", 64'(hi), 64'(m_hi));
      if (done) break;
    end
    check_val("busy.latency", 64'(k), 64'(W + 1));
    check_val("busy.lo", 64'(lo), 64'(10));
    check_val("busy.hi", 64'(hi), 64'(0));
    m_hi = '0;
    m_lo = 32'd10;
    @(posedge clk);
    #1;
    check_val("busy.idle", 64'(busy), 64'(0));

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("abort.hi", 64'(hi), 64'(0));
    check_val("abort.lo", 64'(lo), 64'(0));
    check_val("abort.busy", 64'(busy), 64'(0));
    check_val("abort.done", 64'(done), 64'(0));
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) saw = 1'b1;
    end
    check_val("abort.no_done", 64'(saw), 64'(0));
    mt_write(1'b0, 1'b1, 32'h1234);

    // Start accepted on the first edge after reset release
    @(posedge clk);
    #1 reset_n = 1'b0;
    m_hi = '0;
    m_lo = '0;
    run_div(1'b0, 32'd20, 32'd6, 1'b0, 1'b0, '0, 1'b1);

    // Simultaneous start and MTHI/MTLO in IDLE
    run_div(1'b0, 32'd200, 32'd9, 1'b1, 1'b1, 32'h5555, 1'b0);

    // Randomized divides interleaved with register writes
    for (int i = 0; i < 60; i++) begin
      sg = 1'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = '1; sg = 1'b1; end
        2: b = W'($urandom_range(1, 15));
        3: a = W'($urandom_range(0, 100));
        4: b = {{(W-4){b[3]}}, b[3:0]};
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) mt_write(1'($urandom), 1'($urandom), $urandom);
      run_div(sg, a, b, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_hilo_div_unit
`default_nettype wire

// File: doc/hilo_div_unit.md
HILO_DIV_UNIT -- requirements
Module: hilo_div_unit

Interface
REQ-001 The block SHALL have the parameter DIV_W, default 32, giving the operand and result width.
REQ-002 The block SHALL have one clock, clk, and one reset, reset_n, which is asynchronous and active-low; both SHALL be listed first, as below.
REQ-003 The block SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request a divide; op_a, op_b and is_signed are sampled on the same edge.
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU.
- op_a  in  DIV_W  dividend (rs).
- op_b  in  DIV_W  divisor (rt).
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  DIV_W  MTHI/MTLO data.
- hi  out  DIV_W  HI register (remainder); MFHI source.
- lo  out  DIV_W  LO register (quotient); MFLO source.
- busy  out  1  divide in progress.
- stall  out  1  combinational start | busy; holds the pipeline.
- done  out  1  one-cycle pulse when HI/LO have been updated by a divide.
- div_zero  out  1  sticky: last divide had op_b == 0; cleared by the next start.

Function
REQ-004 State machine SHALL be IDLE, RUN, FIX.
- IDLE -> RUN on start with op_b != 0.
- IDLE -> FIX on start with op_b == 0.
- RUN -> FIX when the iteration counter reaches 0.
- FIX -> IDLE unconditionally.
REQ-005 On accepting start, the block SHALL capture the absolute values |op_a| and |op_b| (unsigned when is_signed = 0), plus sign_q = a[31]^b[31] and sign_r = a[31], both forced to 0 when unsigned.
REQ-006 RUN SHALL last exactly DIV_W cycles, with one quotient bit resolved per cycle by the divu_core sub-module.
REQ-007 In FIX, the block SHALL write lo = sign_q ? -Q : Q and hi = sign_r ? -R : R, registered on the FIX edge.
REQ-008 done SHALL be high for exactly the one cycle following the FIX edge; busy SHALL be high in RUN and FIX and low in IDLE.
REQ-009 Latency: with start sampled at edge N and op_b != 0, done and the new hi/lo SHALL be visible after edge N+DIV_W+1 (N+33 at the default width).
REQ-010 Divide by zero SHALL skip RUN and produce lo = all ones and hi = op_a (raw, unsigned semantics), with done after edge N+1 and div_zero set.
REQ-011 Signed overflow (0x8000_0000 / -1) SHALL yield lo = 0x8000_0000 and hi = 0 with no flag.
REQ-012 start while busy SHALL be ignored; operands SHALL NOT be resampled.
REQ-013 hi_we/lo_we in IDLE SHALL write wdata on that edge; while busy they SHALL be ignored.
REQ-014 Simultaneous start and hi_we/lo_we in IDLE SHALL apply the write and also start the divide; the divide result SHALL later overwrite both registers.
REQ-015 hi and lo SHALL hold their value at all times except when written by FIX, MTHI/MTLO or reset.

Reset
REQ-016 reset_n low SHALL asynchronously force:
- state = IDLE;
- hi = lo = 0;
- busy = done = div_zero = 0;
- the counter and all datapath registers in divu_core = 0.
REQ-017 Reset during RUN or FIX SHALL abort the divide with no done pulse and no HI/LO update.
REQ-018 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Structure
REQ-019 A shared package div_pkg SHALL hold the state enum (IDLE/RUN/FIX), DIV_W, CNT_W = 6 and the divide-by-zero quotient constant (all ones).
REQ-020 The iterative unsigned shift-subtract datapath SHALL be the sub-module divu_core, with these ports:
- clk, reset_n;
- load, dividend, divisor;
- q, r, finish.
REQ-021 Sign conversion, the FSM, the HI/LO registers and MTHI/MTLO handling SHALL live in hilo_div_unit.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- DIVU 100 / 7 -> after 33 cycles lo = 14, hi = 2, done pulses once, busy low the next cycle.
- DIV -7 / 2 -> lo = 0xFFFF_FFFD (-3), hi = 0xFFFF_FFFF (-1); DIV 7 / -2 -> lo = -3, hi = 1.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> lo = 0x8000_0000, hi = 0, div_zero = 0.
- DIVU 5 / 0 -> done after 1 cycle, lo = 0xFFFF_FFFF, hi = 5, div_zero = 1; next DIVU 9 / 3 clears div_zero and gives lo = 3, hi = 0.
- start 50 / 5 then second start 1 / 1 at cycle 10, and hi_we = 1 with wdata = 0xAAAA at cycle 12 -> both ignored; final lo = 10, hi = 0.
- reset_n pulsed low at cycle 20 of a divide -> hi = lo = 0 immediately, no done pulse, state IDLE; MTLO 0x1234 in IDLE -> lo = 0x1234 on the next edge.
